// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for mux_sel_pipe: upstream select request on the in_* side,
// registered result on the out_* side, plus the sticky bad-select flag.
interface mux_sel_pipe_if #(
  parameter int WIDTH  = 3,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// N-way registered select stage with a one-entry skid slot; out_data is always
// the oldest held item, so drains never reorder, drop or duplicate selections.
module mux_sel_pipe #(
  parameter int WIDTH  = 3,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic           clk,
  input logic           reset,
  mux_sel_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             sel_err_q;
  logic [WIDTH-1:0] sel_val;
  logic             sel_bad;
  logic             acc, drn;
  logic             load_main, load_skid, skid_to_main;

  // Out-of-range selects fall back to input 0 and flag the error.
  always_comb begin
    sel_val = bus.in_data[WIDTH-1:0];
    sel_bad = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(bus.in_sel) == k) begin
        sel_val = bus.in_data[k*WIDTH +: WIDTH];
        sel_bad = 1'b0;
      end
    end
  end

  assign bus.in_ready  = ~reset & (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_q;
  assign bus.sel_err   = sel_err_q;

  assign acc = bus.in_valid & bus.in_ready;
  assign drn = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (acc && drn) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drn) begin
          state_d      = ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main)    main_q <= sel_val;
      if (skid_to_main) main_q <= skid_q;
      if (load_skid)    skid_q <= sel_val;
      if (acc && sel_bad) sel_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: two instances (4-input and 3-input) share the
// same stimulus and are checked every cycle against a queue-based occupancy model.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        out_ready;

  int unsigned total  = 0;
  int unsigned passed = 0;

  mux_sel_pipe_if #(.WIDTH(3), .NUM_IN(4), .SEL_W(2)) bus_a ();
  mux_sel_pipe_if #(.WIDTH(3), .NUM_IN(3), .SEL_W(2)) bus_b ();

  assign bus_a.in_data   = din;
  assign bus_a.in_sel    = in_sel;
  assign bus_a.in_valid  = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_data   = din[8:0];
  assign bus_b.in_sel    = in_sel;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.out_ready = out_ready;

  mux_sel_pipe #(.WIDTH(3), .NUM_IN(4), .SEL_W(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mux_sel_pipe #(.WIDTH(3), .NUM_IN(3), .SEL_W(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: each instance is a FIFO of at most two selected values.
  int unsigned cnt[2];
  logic [2:0]  item[2][2];
  logic [2:0]  last[2];
  bit          err[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   n;
      int   s;
      bit   drn;
      bit   acc;
      logic [2:0] v;
      n = (d == 0) ? 4 : 3;
      if (reset) begin
        cnt[d]  = 0;
        last[d] = 3'd0;
        err[d]  = 1'b0;
      end else begin
        s   = int'(in_sel);
        drn = (cnt[d] > 0) && out_ready;
        acc = in_valid && (cnt[d] < 2);
        v   = (s < n) ? din[s*3 +: 3] : din[2:0];
        if (acc && s >= n) err[d] = 1'b1;
        if (drn) begin
          item[d][0] = item[d][1];
          cnt[d]--;
        end
        if (acc) begin
          item[d][cnt[d]] = v;
          cnt[d]++;
        end
        if (cnt[d] > 0) last[d] = item[d][0];
      end
    end
  end

  always @(negedge clk) begin
    chk("a_in_ready",  32'(bus_a.in_ready),  32'(!reset && cnt[0] < 2));
    chk("a_out_valid", 32'(bus_a.out_valid), 32'(cnt[0] > 0));
    chk("a_out_data",  32'(bus_a.out_data),  32'(last[0]));
    chk("a_sel_err",   32'(bus_a.sel_err),   32'(err[0]));
    chk("b_in_ready",  32'(bus_b.in_ready),  32'(!reset && cnt[1] < 2));
    chk("b_out_valid", 32'(bus_b.out_valid), 32'(cnt[1] > 0));
    chk("b_out_data",  32'(bus_b.out_data),  32'(last[1]));
    chk("b_sel_err",   32'(bus_b.sel_err),   32'(err[1]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [11:0] BASE = {3'd7, 3'd6, 3'd5, 3'd3};

  initial begin
    logic [2:0] exp_s [4];
    logic [7:0] pat_v;
    logic [7:0] pat_r;
    exp_s = '{3'd3, 3'd5, 3'd6, 3'd7};
    reset = 1'b1; din = BASE; in_sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0;

    // 1: reset values
    step(); step();
    chk("rst_in_ready",  32'(bus_a.in_ready),  0);
    chk("rst_out_valid", 32'(bus_a.out_valid), 0);
    chk("rst_out_data",  32'(bus_a.out_data),  0);
    chk("rst_sel_err",   32'(bus_a.sel_err),   0);
    reset = 1'b0;
    #1 chk("post_rst_in_ready", 32'(bus_a.in_ready), 1);

    // 2: streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i);
      step();
      chk("stream_data",  32'(bus_a.out_data),  32'(exp_s[i]));
      chk("stream_valid", 32'(bus_a.out_valid), 1);
      chk("stream_ready", 32'(bus_a.in_ready),  1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drained", 32'(bus_a.out_valid), 0);

    // 3: fill under stall, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    step();
    chk("stall1_data",  32'(bus_a.out_data), 5);
    chk("stall1_ready", 32'(bus_a.in_ready), 1);
    in_sel = 2'd2;
    step();
    chk("full_ready", 32'(bus_a.in_ready), 0);
    chk("full_data",  32'(bus_a.out_data), 5);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("drain1_data",  32'(bus_a.out_data), 6);
    chk("drain1_ready", 32'(bus_a.in_ready), 1);
    step();
    chk("drain2_valid", 32'(bus_a.out_valid), 0);
    chk("drain2_hold",  32'(bus_a.out_data),  6);

    // 4: inputs change while the stored item is stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    step();
    in_valid = 1'b0; in_sel = 2'd2; din = {3'd4, 3'd2, 3'd1, 3'd0};
    step(); step();
    chk("hold_data", 32'(bus_a.out_data), 5);
    din = BASE; out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // 5: out-of-range select on the 3-input instance, sticky flag
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("b_err_cleared", 32'(bus_b.sel_err), 0);
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd3;
    step();
    chk("b_bad_data", 32'(bus_b.out_data), 3);
    chk("b_bad_err",  32'(bus_b.sel_err),  1);
    chk("a_sel3_ok",  32'(bus_a.out_data), 7);
    in_sel = 2'd1;
    step();
    chk("b_after_data", 32'(bus_b.out_data), 5);
    chk("b_sticky",     32'(bus_b.sel_err),  1);
    in_valid = 1'b0;
    step();

    // 6: reset while full
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    chk("pre_rst_full", 32'(bus_a.in_ready), 0);
    in_valid = 1'b0; reset = 1'b1;
    step();
    chk("midrst_valid", 32'(bus_a.out_valid), 0);
    chk("midrst_data",  32'(bus_a.out_data),  0);
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", 32'(bus_a.out_valid), 0);
    end

    // Mixed valid/ready patterns, checked by the per-cycle model
    pat_v = 8'b1011_0111;
    pat_r = 8'b0110_1001;
    for (int i = 0; i < 24; i++) begin
      in_valid  = pat_v[i % 8];
      out_ready = pat_r[(i * 3) % 8];
      in_sel    = 2'(i % 4);
      din       = BASE ^ 12'(i * 37);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
